alu_issue_seq: RTL and testbench

Operation sequencer that drives the 16-bit ALU from the control side. It accepts 16-bit instruction words over a valid/ready handshake, reads operands from a private 4-entry register file, and presents a, b, imm_val, imm and func to the ALU. It then waits a configurable ALU latency, writes the ALU result back, and latches the 8-bit status. It sits between the microcpu fetch path and the ALU.

---
 rtl/alu_seq_pkg.sv | 58 +++++
 rtl/alu_seq_regfile.sv | 41 ++++
 rtl/alu_issue_seq.sv | 159 +++++++++++++++
 tb/tb_alu_issue_seq.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types, field positions and decode helpers for the ALU issue sequencer.
package alu_seq_pkg;

   localparam int NUM_REGS = 4;
   localparam int REG_W    = 16;
   localparam int FUNC_W   = 4;
   localparam int STATUS_W = 8;
   localparam int INSTR_W  = 16;
   localparam int REG_AW   = 2;
   localparam int IMM8_W   = 8;

   localparam int FUNC_MSB = 15;
   localparam int FUNC_LSB = 12;
   localparam int IMM_BIT  = 11;
   localparam int RD_MSB   = 10;
   localparam int RD_LSB   = 9;
   localparam int RS_MSB   = 8;
   localparam int RS_LSB   = 7;
   localparam int RT_MSB   = 6;
   localparam int RT_LSB   = 5;
   localparam int HI_BIT   = 8;
   localparam int IMM8_MSB = 7;
   localparam int IMM8_LSB = 0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } seq_state_t;

   typedef struct packed {
      logic [FUNC_W-1:0] func;
      logic              imm;
      logic [REG_AW-1:0] rd;
      logic [REG_AW-1:0] rs;
      logic [REG_AW-1:0] rt;
      logic              hi;
      logic [IMM8_W-1:0] imm8;
   } instr_fields_t;

   // rs/rt and hi/imm8 overlap; the imm bit decides which view is meaningful.
   function automatic instr_fields_t decode_instr(input logic [INSTR_W-1:0] w);
      instr_fields_t f;
      f.func = w[FUNC_MSB:FUNC_LSB];
      f.imm  = w[IMM_BIT];
      f.rd   = w[RD_MSB:RD_LSB];
      f.rs   = w[RS_MSB:RS_LSB];
      f.rt   = w[RT_MSB:RT_LSB];
      f.hi   = w[HI_BIT];
      f.imm8 = w[IMM8_MSB:IMM8_LSB];
      return f;
   endfunction

   function automatic logic [REG_W-1:0] expand_imm(input logic hi, input logic [IMM8_W-1:0] imm8);
      return hi ? {imm8, 8'h00} : {8'h00, imm8};
   endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// Four-entry operand register file: one write port, three combinational read ports.
module alu_seq_regfile
   import alu_seq_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [REG_AW-1:0] waddr,
   input  logic [REG_W-1:0]  wdata,
   input  logic [REG_AW-1:0] raddr_a,
   output logic [REG_W-1:0]  rdata_a,
   input  logic [REG_AW-1:0] raddr_b,
   output logic [REG_W-1:0]  rdata_b,
   input  logic [REG_AW-1:0] raddr_d,
   output logic [REG_W-1:0]  rdata_d
);

   logic [NUM_REGS-1:0][REG_W-1:0] regs_q;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
         logic [REG_W-1:0] q_reg;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               q_reg <= '0;
            end else if (we && (waddr == REG_AW'(gi))) begin
               q_reg <= wdata;
            end
         end

         assign regs_q[gi] = q_reg;
      end
   endgenerate

   assign rdata_a = regs_q[raddr_a];
   assign rdata_b = regs_q[raddr_b];
   assign rdata_d = regs_q[raddr_d];

endmodule

// File: rtl/alu_issue_seq.sv
// Issues one instruction at a time to the ALU, waits ALU_LAT+1 cycles and writes the result back.
// Optional ALU_SEQ_ACCEPT_IN_DONE_EN: accept the next instruction during the writeback cycle.
module alu_issue_seq
   import alu_seq_pkg::*;
#(
   parameter int ALU_LAT = 1
)
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                instr_valid,
   input  logic [INSTR_W-1:0]  instr,
   output logic                instr_ready,
   output logic [REG_W-1:0]    alu_a,
   output logic [REG_W-1:0]    alu_b,
   output logic [REG_W-1:0]    alu_imm_val,
   output logic                alu_imm,
   output logic [FUNC_W-1:0]   alu_func,
   input  logic [REG_W-1:0]    alu_out,
   input  logic [STATUS_W-1:0] alu_status,
   output logic                wb_valid,
   output logic [REG_AW-1:0]   wb_rd,
   output logic [REG_W-1:0]    wb_data,
   output logic [STATUS_W-1:0] status_q,
   output logic                busy
);

   localparam int CNT_W = 3;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ALU_LAT);

   seq_state_t          state_reg;
   seq_state_t          state_next;
   logic [CNT_W-1:0]    cnt_reg;
   logic [REG_AW-1:0]   rd_reg;
   logic [REG_AW-1:0]   wb_rd_reg;
   logic [REG_W-1:0]    wb_data_reg;
   logic [STATUS_W-1:0] status_reg;

   logic [REG_W-1:0]    alu_a_reg;
   logic [REG_W-1:0]    alu_b_reg;
   logic [REG_W-1:0]    alu_imm_val_reg;
   logic                alu_imm_reg;
   logic [FUNC_W-1:0]   alu_func_reg;

   instr_fields_t       fields;
   logic [REG_W-1:0]    rf_rs;
   logic [REG_W-1:0]    rf_rt;
   logic [REG_W-1:0]    rf_rd;
   logic [REG_W-1:0]    rs_val;
   logic [REG_W-1:0]    rt_val;
   logic [REG_W-1:0]    rd_val;
   logic                accept;
   logic                exec_last;

   assign fields    = decode_instr(instr);
   assign exec_last = (state_reg == EXEC) && (cnt_reg == CNT_LAST);

`ifdef ALU_SEQ_ACCEPT_IN_DONE_EN
   assign instr_ready = (state_reg == IDLE) || (state_reg == DONE);
`else
   assign instr_ready = (state_reg == IDLE);
`endif

   assign accept = instr_valid && instr_ready;

   alu_seq_regfile u_regfile (
      .clk     (clk),
      .rst_n   (rst_n),
      .we      (exec_last),
      .waddr   (rd_reg),
      .wdata   (alu_out),
      .raddr_a (fields.rs),
      .rdata_a (rf_rs),
      .raddr_b (fields.rt),
      .rdata_b (rf_rt),
      .raddr_d (fields.rd),
      .rdata_d (rf_rd)
   );

`ifdef ALU_SEQ_ACCEPT_IN_DONE_EN
   // Operands picked up in DONE must see the result being retired in that same cycle.
   logic wb_fwd;
   assign wb_fwd = (state_reg == DONE);
   assign rs_val = (wb_fwd && (fields.rs == wb_rd_reg)) ? wb_data_reg : rf_rs;
   assign rt_val = (wb_fwd && (fields.rt == wb_rd_reg)) ? wb_data_reg : rf_rt;
   assign rd_val = (wb_fwd && (fields.rd == wb_rd_reg)) ? wb_data_reg : rf_rd;
`else
   assign rs_val = rf_rs;
   assign rt_val = rf_rt;
   assign rd_val = rf_rd;
`endif

   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         IDLE:    if (accept) state_next = EXEC;
         EXEC:    if (exec_last) state_next = DONE;
         DONE:    state_next = accept ? EXEC : IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         if (accept) begin
            cnt_reg <= '0;
         end else if (state_reg == EXEC) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
         end
      end
   end

   // Issue registers stay put until the next acceptance so the ALU sees stable inputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_a_reg       <= '0;
         alu_b_reg       <= '0;
         alu_imm_val_reg <= '0;
         alu_imm_reg     <= 1'b0;
         alu_func_reg    <= '0;
         rd_reg          <= '0;
      end else if (accept) begin
         alu_a_reg       <= fields.imm ? '0 : rs_val;
         alu_b_reg       <= fields.imm ? rd_val : rt_val;
         alu_imm_val_reg <= fields.imm ? expand_imm(fields.hi, fields.imm8) : '0;
         alu_imm_reg     <= fields.imm;
         alu_func_reg    <= fields.func;
         rd_reg          <= fields.rd;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_rd_reg   <= '0;
         wb_data_reg <= '0;
         status_reg  <= '0;
      end else if (exec_last) begin
         wb_rd_reg   <= rd_reg;
         wb_data_reg <= alu_out;
         status_reg  <= alu_status;
      end
   end

   assign alu_a       = alu_a_reg;
   assign alu_b       = alu_b_reg;
   assign alu_imm_val = alu_imm_val_reg;
   assign alu_imm     = alu_imm_reg;
   assign alu_func    = alu_func_reg;
   assign wb_valid    = (state_reg == DONE);
   assign wb_rd       = wb_rd_reg;
   assign wb_data     = wb_data_reg;
   assign status_q    = status_reg;
   assign busy        = (state_reg != IDLE);

endmodule

// File: tb/tb_alu_issue_seq.sv
// Bench for alu_issue_seq: pipelined ALU model, register-file reference model, directed and random streams.
module tb_alu_issue_seq;

   localparam int ALU_LAT = 2;
`ifdef ALU_SEQ_ACCEPT_IN_DONE_EN
   localparam int SPACING = ALU_LAT + 2;
`else
   localparam int SPACING = ALU_LAT + 3;
`endif

   typedef struct packed {
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] iv;
      logic        imm;
      logic [3:0]  func;
   } ops_t;

   logic        clk;
   logic        rst_n;
   logic        instr_valid;
   logic [15:0] instr;
   logic        instr_ready;
   logic [15:0] alu_a;
   logic [15:0] alu_b;
   logic [15:0] alu_imm_val;
   logic        alu_imm;
   logic [3:0]  alu_func;
   logic [15:0] alu_out;
   logic [7:0]  alu_status;
   logic        wb_valid;
   logic [1:0]  wb_rd;
   logic [15:0] wb_data;
   logic [7:0]  status_q;
   logic        busy;

   int n_assert = 0;
   int n_fail   = 0;

   logic [15:0] mreg [4];
   logic [1:0]  q_rd   [$];
   logic [15:0] q_data [$];
   logic [7:0]  q_stat [$];

   alu_issue_seq #(.ALU_LAT(ALU_LAT)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .instr_valid (instr_valid),
      .instr       (instr),
      .instr_ready (instr_ready),
      .alu_a       (alu_a),
      .alu_b       (alu_b),
      .alu_imm_val (alu_imm_val),
      .alu_imm     (alu_imm),
      .alu_func    (alu_func),
      .alu_out     (alu_out),
      .alu_status  (alu_status),
      .wb_valid    (wb_valid),
      .wb_rd       (wb_rd),
      .wb_data     (wb_data),
      .status_q    (status_q),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ALU behaviour: returns {status, result}.
   function automatic logic [23:0] alu_calc(input logic [3:0] f, input logic [15:0] a,
                                            input logic [15:0] b, input logic im,
                                            input logic [15:0] iv);
      logic [15:0] ob;
      logic [15:0] r;
      ob = im ? iv : b;
      case (f)
         4'd0:    r = a ^ ob;
         4'd1:    r = a & ob;
         4'd2:    r = a - ob;
         4'd3:    r = a + ob;
         default: r = (a + ob) ^ {12'h000, f};
      endcase
      return {f ^ r[15:12], r[3:0] ^ r[11:8], r};
   endfunction

   logic [23:0] alu_pipe [ALU_LAT];
   initial for (int i = 0; i < ALU_LAT; i++) alu_pipe[i] = '0;
   always @(posedge clk) begin
      alu_pipe[0] <= alu_calc(alu_func, alu_a, alu_b, alu_imm, alu_imm_val);
      for (int i = 1; i < ALU_LAT; i++) alu_pipe[i] <= alu_pipe[i-1];
   end
   assign alu_out    = alu_pipe[ALU_LAT-1][15:0];
   assign alu_status = alu_pipe[ALU_LAT-1][23:16];

   // Expected ALU inputs for an instruction word, from the reference register contents.
   function automatic ops_t model_ops(input logic [15:0] w);
      ops_t o;
      int rd, rs, rt;
      rd = int'((w >> 9) & 16'h3);
      rs = int'((w >> 7) & 16'h3);
      rt = int'((w >> 5) & 16'h3);
      o.func = w[15:12];
      o.imm  = w[11];
      if (w[11]) begin
         o.a  = 16'h0000;
         o.b  = mreg[rd];
         o.iv = w[8] ? ((w & 16'h00FF) << 8) : (w & 16'h00FF);
      end else begin
         o.a  = mreg[rs];
         o.b  = mreg[rt];
         o.iv = 16'h0000;
      end
      return o;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] dut_ops();
      return 64'({alu_a, alu_b, alu_imm_val, alu_imm, alu_func});
   endfunction

   task automatic observe_wb();
      logic [1:0]  erd;
      logic [15:0] edata;
      logic [7:0]  est;
      if (wb_valid) begin
         if (q_rd.size() == 0) begin
            check("wb_unexpected", 64'(wb_valid), 64'(0));
         end else begin
            erd   = q_rd.pop_front();
            edata = q_data.pop_front();
            est   = q_stat.pop_front();
            check("wb_rd", 64'(wb_rd), 64'(erd));
            check("wb_data", 64'(wb_data), 64'(edata));
            check("status_q", 64'(status_q), 64'(est));
            mreg[erd] = edata;
            $display("wb rd=%0d data=%h status=%h", wb_rd, wb_data, status_q);
         end
      end
   endtask

   // One isolated instruction with cycle-exact checks; DUT must be idle on entry.
   task automatic issue_one(input logic [15:0] w, output logic [15:0] got);
      ops_t        eo;
      logic [23:0] r;
      int          g, hits, rd;
      @(negedge clk);
      instr = w;
      instr_valid = 1'b1;
      g = 0;
      while (!instr_ready && g < 50) begin
         @(negedge clk);
         g++;
      end
      check("ready_wait", 64'(instr_ready), 64'(1));
      eo = model_ops(w);
      r  = alu_calc(eo.func, eo.a, eo.b, eo.imm, eo.iv);
      rd = int'((w >> 9) & 16'h3);
      @(negedge clk);
      instr_valid = 1'b0;
      instr = 16'($urandom);
      check("ops_issue", dut_ops(), 64'(eo));
      check("busy_exec", 64'({busy, instr_ready}), 64'(2'b10));
      hits = 0;
      for (int n = 2; n <= ALU_LAT + 1; n++) begin
         @(negedge clk);
         if (wb_valid) hits++;
         instr_valid = (n <= ALU_LAT);
         instr = 16'($urandom);
      end
      check("wb_early", 64'(hits), 64'(0));
      check("ops_hold", dut_ops(), 64'(eo));
      @(negedge clk);
      check("wb_pulse", 64'(wb_valid), 64'(1));
      check("wb_rd_one", 64'(wb_rd), 64'(rd));
      check("wb_data_one", 64'(wb_data), 64'(r[15:0]));
      check("status_one", 64'(status_q), 64'(r[23:16]));
      got = wb_data;
      mreg[rd] = r[15:0];
      $display("issue instr=%h rd=%0d data=%h status=%h", w, wb_rd, wb_data, status_q);
      @(negedge clk);
      check("wb_end", 64'({wb_valid, busy, instr_ready}), 64'(3'b001));
   endtask

   task automatic run_stream(input int ncyc, input int pct);
      ops_t        eo;
      logic [23:0] r;
      logic        ops_due;
      int          last_acc;
      last_acc = -1;
      ops_due  = 1'b0;
      eo       = '0;
      for (int c = 0; c < ncyc; c++) begin
         @(negedge clk);
         if (ops_due) begin
            check("stream_ops", dut_ops(), 64'(eo));
            ops_due = 1'b0;
         end
         observe_wb();
         instr = 16'($urandom);
         instr_valid = ($urandom_range(99) < pct);
         if (instr_valid && instr_ready) begin
            eo = model_ops(instr);
            r  = alu_calc(eo.func, eo.a, eo.b, eo.imm, eo.iv);
            q_rd.push_back(2'((instr >> 9) & 16'h3));
            q_data.push_back(r[15:0]);
            q_stat.push_back(r[23:16]);
            if (last_acc >= 0) begin
               if (pct == 100) check("spacing", 64'(c - last_acc), 64'(SPACING));
               else            check("spacing_min", 64'((c - last_acc) >= SPACING), 64'(1));
            end
            last_acc = c;
            ops_due  = 1'b1;
         end
      end
      instr_valid = 1'b0;
      for (int k = 0; k < 4 * SPACING && q_rd.size() > 0; k++) begin
         @(negedge clk);
         if (ops_due) begin
            check("stream_ops", dut_ops(), 64'(eo));
            ops_due = 1'b0;
         end
         observe_wb();
      end
      check("drain", 64'(q_rd.size()), 64'(0));
      @(negedge clk);
      check("stream_idle", 64'(busy), 64'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] got;
      int          hits;
      int          g;
      rst_n = 1'b0;
      instr_valid = 1'b0;
      instr = 16'h0000;
      for (int i = 0; i < 4; i++) mreg[i] = 16'h0000;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_ops", dut_ops(), 64'(0));
      check("rst_wb", 64'({wb_valid, wb_rd, wb_data}), 64'(0));
      check("rst_status", 64'(status_q), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_ready", 64'(instr_ready), 64'(1));

      issue_one(16'h0B12, got);
      check("imm_hi_data", 64'(got), 64'(16'h1200));
      check("imm_hi_sel", 64'({alu_imm, alu_imm_val}), 64'({1'b1, 16'h1200}));

      issue_one(16'h0C05, got);
      issue_one(16'h0E04, got);
      issue_one(16'h3160, got);
      check("regop_data", 64'(got), 64'(16'd9));
      check("regop_ops", 64'({alu_a, alu_b, alu_func}), 64'({16'd5, 16'd4, 4'd3}));

      run_stream(120, 100);
      run_stream(150, 60);

      // Reset in the second EXEC cycle discards the instruction and clears the registers.
      @(negedge clk);
      instr = 16'h0B34;
      instr_valid = 1'b1;
      g = 0;
      while (!instr_ready && g < 50) begin
         @(negedge clk);
         g++;
      end
      check("ready_wait_rst", 64'(instr_ready), 64'(1));
      @(negedge clk);
      instr_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      hits = 0;
      repeat (ALU_LAT + 4) begin
         @(negedge clk);
         if (wb_valid) hits++;
      end
      check("rst_mid_busy", 64'(busy), 64'(0));
      rst_n = 1'b1;
      repeat (ALU_LAT + 3) begin
         @(negedge clk);
         if (wb_valid) hits++;
      end
      check("rst_mid_no_wb", 64'(hits), 64'(0));
      check("rst_mid_state", 64'({busy, instr_ready}), 64'(2'b01));
      check("rst_mid_regs", 64'({wb_data, status_q, alu_a, alu_b}), 64'(0));
      for (int i = 0; i < 4; i++) mreg[i] = 16'h0000;
      $display("reset mid-EXEC applied");

      issue_one(16'h06C0, got);
      check("rst_rf_clear", 64'(got), 64'(16'h0000));

      run_stream(80, 100);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
